// File: rtl/dircc_avalon_st_packet_transmitter.sv
// dircc_avalon_st_packet_transmitter: serialises a 240-bit dircc packet into eight 32-bit Avalon-ST beats
module dircc_avalon_st_packet_transmitter #(
  parameter int IDLE_GAP = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [239:0] packet_data,
  input  logic         send_valid,
  output logic         send_ready,
  output logic         send_nearly_done,
  output logic         send_done,
  output logic [31:0]  out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_startofpacket,
  output logic         out_endofpacket,
  output logic [1:0]   out_empty
);
  // Packet layout, MSB first:
  //   dest {hw_addr[31:0], sw_addr[15:0], port[6:0], flag} [239:184]
  //   src  {hw_addr[31:0], sw_addr[15:0], port[6:0], flag} [183:128]
  //   lamport[31:0] [127:96], data[95:0] [95:0]
  localparam logic [1:0] IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2;
  logic [1:0] state_q, state_d;
  logic [2:0] beat_q, beat_d;
  logic [3:0] gap_q, gap_d;
  logic [239:0] pkt_q, pkt_d;
  logic done_q, done_d;
  logic accept, last_acc;
  logic [7:0][31:0] words;
  assign send_ready = state_q == IDLE && !reset;
  assign accept = send_ready && send_valid;
  assign out_valid = state_q == SEND;
  assign last_acc = out_valid && beat_q == 3'd7 && out_ready;
  assign words = {pkt_q[95:64], pkt_q[63:32], pkt_q[31:0], pkt_q[127:96],
                  pkt_q[151:128], 8'h00, pkt_q[183:152], pkt_q[207:184], 8'h00, pkt_q[239:208]};
  assign out_data = out_valid ? words[beat_q] : '0;
  assign out_startofpacket = out_valid && beat_q == 3'd0;
  assign out_endofpacket = out_valid && beat_q == 3'd7;
  assign send_nearly_done = out_endofpacket;
  assign out_empty = 2'b00;
  assign send_done = done_q;
  // Next state: capture in IDLE, step beats on handshake, count down the inter-packet gap
  always_comb begin
    state_d = accept ? SEND
            : last_acc ? (IDLE_GAP > 0 ? GAP : IDLE)
            : (state_q == GAP && gap_q <= 4'd1) ? IDLE : state_q;
    beat_d = accept ? 3'd0 : (out_valid && out_ready) ? beat_q + 3'd1 : beat_q;
    gap_d = last_acc ? 4'(IDLE_GAP) : state_q == GAP ? gap_q - 4'd1 : gap_q;
    pkt_d = accept ? packet_data : pkt_q;
    done_d = last_acc;
  end
  // State registers; reset abandons any packet in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q <= '0;
      gap_q <= '0;
      pkt_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      gap_q <= gap_d;
      pkt_q <= pkt_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_dircc_avalon_st_packet_transmitter.sv
// tb_dircc_avalon_st_packet_transmitter: randomized directed bench with a reassembling sink model
module tb_dircc_avalon_st_packet_transmitter;
  typedef struct packed {
    logic [31:0] hw;
    logic [15:0] sw;
    logic [6:0]  port;
    logic        flag;
  } addr_t;
  typedef struct packed {
    addr_t       dest;
    addr_t       src;
    logic [31:0] lamport;
    logic [95:0] data;
  } pkt_t;

  logic clk = 0, reset = 1;
  always #5 clk = ~clk;

  logic [239:0] packet_data = '0;
  logic send_valid = 0, out_ready = 1;
  logic send_ready, send_nearly_done, send_done, out_valid, out_startofpacket, out_endofpacket;
  logic [31:0] out_data;
  logic [1:0] out_empty;

  logic [239:0] g_pkt = '0;
  logic g_sv = 0, g_rdy = 1;
  logic g_ready, g_nearly, g_done, g_valid, g_sop, g_eop;
  logic [31:0] g_data;
  logic [1:0] g_empty;

  int n_cmp = 0, n_err = 0;

  dircc_avalon_st_packet_transmitter #(.IDLE_GAP(0)) dut (
    .clk(clk), .reset(reset), .packet_data(packet_data), .send_valid(send_valid),
    .send_ready(send_ready), .send_nearly_done(send_nearly_done), .send_done(send_done),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket), .out_empty(out_empty)
  );

  dircc_avalon_st_packet_transmitter #(.IDLE_GAP(3)) dut_gap (
    .clk(clk), .reset(reset), .packet_data(g_pkt), .send_valid(g_sv),
    .send_ready(g_ready), .send_nearly_done(g_nearly), .send_done(g_done),
    .out_data(g_data), .out_valid(g_valid), .out_ready(g_rdy),
    .out_startofpacket(g_sop), .out_endofpacket(g_eop), .out_empty(g_empty)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic pkt_t rnd();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v[239:0];
  endfunction

  // Sends one packet on the IDLE_GAP=0 instance, acting as sink; stall_at>=8 means no stall
  task automatic xfer(input pkt_t p, input int stall_at, input int stall_len, input bit poke);
    logic [31:0] w [8];
    logic [31:0] held;
    int idx, stalls, cyc, exp_cyc;
    pkt_t got;
    packet_data = p;
    send_valid = 1;
    out_ready = 1;
    chk("accept_ready", send_ready, 1);
    tick();
    packet_data = rnd();
    idx = 0; stalls = 0; cyc = 0; held = '0;
    while (idx < 8 && cyc < 100) begin
      send_valid = poke && idx < 6;
      chk("valid", out_valid, 1);
      chk("sop", out_startofpacket, idx == 0);
      chk("eop", out_endofpacket, idx == 7);
      chk("nearly_done", send_nearly_done, idx == 7);
      chk("empty", out_empty, 0);
      chk("busy_ready", send_ready, 0);
      chk("done_during_send", send_done, 0);
      if (idx == stall_at && stalls > 0) chk("stall_hold", out_data, held);
      held = out_data;
      if (idx == stall_at && stalls < stall_len) begin
        out_ready = 0;
        stalls++;
      end else out_ready = 1;
      w[idx] = out_data;
      if (out_ready) idx++;
      tick();
      cyc++;
    end
    send_valid = 0;
    out_ready = 1;
    exp_cyc = 8 + (stall_at < 8 ? stall_len : 0);
    chk("beat_count", idx, 8);
    chk("beat_cycles", cyc, exp_cyc);
    chk("done_pulse", send_done, 1);
    chk("valid_after", out_valid, 0);
    got.dest.hw = w[0];
    {got.dest.sw, got.dest.port, got.dest.flag} = w[1][31:8];
    got.src.hw = w[2];
    {got.src.sw, got.src.port, got.src.flag} = w[3][31:8];
    got.lamport = w[4];
    got.data = {w[7], w[6], w[5]};
    chk("pad1", w[1][7:0], 0);
    chk("pad3", w[3][7:0], 0);
    chk("lamport_beat", w[4], p.lamport);
    chk("reassembled", got, p);
    tick();
    chk("done_once", send_done, 0);
    chk("idle_ready", send_ready, 1);
  endtask

  initial begin
    pkt_t p, pa, pb;
    int cyc;
    // Reset held 10 cycles, then 10 idle cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst_ready", send_ready, 0);
      chk("rst_valid", out_valid, 0);
    end
    reset = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_done", send_done, 0);
    chk("post_rst_nearly", send_nearly_done, 0);
    chk("post_rst_ready", send_ready, 1);
    chk("post_rst_data", out_data, 0);

    // Single directed packet
    p = rnd();
    p.dest.hw = 32'h11223344;
    p.lamport = 32'd5;
    p.data = {24{4'hA}};
    xfer(p, 8, 0, 0);

    // Backpressure at beat 3 for 5 cycles
    xfer(rnd(), 3, 5, 0);

    // Input isolation: data scrambled and send_valid poked during SEND
    xfer(rnd(), 8, 0, 1);

    // Random packets with random stalls
    for (int k = 0; k < 6; k++)
      xfer(rnd(), $urandom_range(0, 9), $urandom_range(1, 4), 1'($urandom_range(0, 1)));

    // Reset mid-packet at beat 5
    p = rnd();
    packet_data = p;
    send_valid = 1;
    tick();
    send_valid = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("pre_rst_beat5", out_data, p.data[31:0]);
    reset = 1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_eop", out_endofpacket, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_nearly", send_nearly_done, 0);
    chk("mid_rst_ready", send_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_rst_done", send_done, 0);
    end
    reset = 0;
    #1;
    chk("rst_release_ready", send_ready, 1);
    chk("rst_release_done", send_done, 0);
    xfer(rnd(), 8, 0, 0);

    // IDLE_GAP=3 back-to-back with send_valid held high
    pa = rnd(); pa.lamport = 32'd0;
    pb = rnd(); pb.lamport = 32'd1;
    g_pkt = pa;
    g_sv = 1;
    chk("gap_first_ready", g_ready, 1);
    tick();
    g_pkt = pb;
    cyc = 0;
    while (!(g_valid && g_eop) && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("gap_eop_reached", g_eop, 1);
    tick();
    cyc = 0;
    while (!g_ready && cyc < 20) begin
      chk("gap_idle_valid", g_valid, 0);
      if (cyc == 0) chk("gap_done", g_done, 1);
      tick();
      cyc++;
    end
    chk("gap_len", cyc, 3);
    tick();
    chk("gap_second_sop", g_sop, 1);
    chk("gap_second_w0", g_data, pb.dest.hw);
    for (int i = 0; i < 4; i++) tick();
    chk("gap_second_lamport", g_data, 32'd1);
    g_sv = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("gap_second_done", g_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
